// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC control with redirect, stall and memory-conflict deferral
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_conflict,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] pc,
  output logic [15:0] npc,
  output logic        fetch_en,
  output logic        flush,
  output logic        pending,
  output logic [15:0] fetch_cnt
);
  typedef enum logic {RUN, PEND} state_t;
  state_t state, state_nx;
  logic [15:0] pend_pc, pend_pc_nx, pc_nx, target;
  logic redirect, advance;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      pend_pc   <= '0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      pend_pc   <= pend_pc_nx;
      fetch_cnt <= fetch_cnt + {15'd0, advance};
    end
  end
  // a redirect seen while the memory is busy is parked in pend_pc until the port frees up
  always_comb begin
    redirect   = jump_en | branch_taken;
    target     = jump_en ? jump_target : branch_target;
    advance    = (state == RUN) & ~redirect & ~mem_conflict & ~stall;
    state_nx   = (state == RUN) ? ((redirect & mem_conflict) ? PEND : RUN)
                                : (mem_conflict ? PEND : RUN);
    pend_pc_nx = (redirect & ((state == PEND) | mem_conflict)) ? target : pend_pc;
    pc_nx      = (state == PEND) ? (mem_conflict ? pc : pend_pc_nx)
               : mem_conflict ? pc
               : redirect ? target
               : stall ? pc : npc;
  end
  always_comb begin
    npc      = pc + 16'd1;
    fetch_en = ~rst & (state == RUN) & ~mem_conflict;
    flush    = rst | (state == PEND) | redirect | mem_conflict;
    pending  = ~rst & (state == PEND);
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven check of pc_sequencer plus reset and wrap sequences
module tb_pc_sequencer;
  logic clk = 0, rst = 1, stall = 0, mem_conflict = 0, jump_en = 0, branch_taken = 0;
  logic [15:0] jump_target = '0, branch_target = '0;
  logic [15:0] pc, npc, fetch_cnt;
  logic fetch_en, flush, pending;
  int errors = 0, checks = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_conflict(mem_conflict),
    .jump_en(jump_en), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .npc(npc), .fetch_en(fetch_en),
    .flush(flush), .pending(pending), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, mc, je;
    logic [15:0] jt;
    logic bt;
    logic [15:0] btgt;
    logic fe, fl, pd;
    logic [15:0] pc_after, cnt_after;
  } vec_t;
  vec_t v[23];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] prev_pc;
    int n;
    v[0]  = '{0,0,0,16'h0000,0,16'h0000,1,0,0,16'h0001,16'd1};
    v[1]  = '{0,0,0,16'h0000,0,16'h0000,1,0,0,16'h0002,16'd2};
    v[2]  = '{0,0,0,16'h0000,0,16'h0000,1,0,0,16'h0003,16'd3};
    v[3]  = '{0,0,0,16'h0000,0,16'h0000,1,0,0,16'h0004,16'd4};
    v[4]  = '{0,0,1,16'h0010,0,16'h0000,1,1,0,16'h0010,16'd4};
    v[5]  = '{1,0,0,16'h0000,0,16'h0000,1,0,0,16'h0010,16'd4};
    v[6]  = '{1,0,0,16'h0000,0,16'h0000,1,0,0,16'h0010,16'd4};
    v[7]  = '{0,0,0,16'h0000,0,16'h0000,1,0,0,16'h0011,16'd5};
    v[8]  = '{0,0,1,16'h0020,0,16'h0000,1,1,0,16'h0020,16'd5};
    v[9]  = '{0,0,1,16'h0200,1,16'h0100,1,1,0,16'h0200,16'd5};
    v[10] = '{0,0,1,16'h0030,0,16'h0000,1,1,0,16'h0030,16'd5};
    v[11] = '{0,1,1,16'h0500,0,16'h0000,0,1,0,16'h0030,16'd5};
    v[12] = '{0,1,0,16'h0000,0,16'h0000,0,1,1,16'h0030,16'd5};
    v[13] = '{0,1,0,16'h0000,0,16'h0000,0,1,1,16'h0030,16'd5};
    v[14] = '{0,0,0,16'h0000,0,16'h0000,0,1,1,16'h0500,16'd5};
    v[15] = '{0,0,0,16'h0000,0,16'h0000,1,0,0,16'h0501,16'd6};
    v[16] = '{0,1,0,16'h0000,0,16'h0000,0,1,0,16'h0501,16'd6};
    v[17] = '{0,1,1,16'h0600,0,16'h0000,0,1,0,16'h0501,16'd6};
    v[18] = '{0,1,0,16'h0000,1,16'h0700,0,1,1,16'h0501,16'd6};
    v[19] = '{1,0,0,16'h0000,0,16'h0000,0,1,1,16'h0700,16'd6};
    v[20] = '{1,0,1,16'h0700,0,16'h0000,1,1,0,16'h0700,16'd6};
    v[21] = '{0,0,0,16'h0000,1,16'hFFFF,1,1,0,16'hFFFF,16'd6};
    v[22] = '{0,0,0,16'h0000,0,16'h0000,1,0,0,16'h0000,16'd7};

    #2;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_cnt", fetch_cnt, 16'h0000);
    chk("reset_fetch_en", {15'd0, fetch_en}, 16'd0);
    chk("reset_flush", {15'd0, flush}, 16'd1);
    chk("reset_pending", {15'd0, pending}, 16'd0);
    @(negedge clk);
    rst = 0;
    prev_pc = 16'h0000;
    for (int i = 0; i < 23; i++) begin
      stall = v[i].stall; mem_conflict = v[i].mc; jump_en = v[i].je;
      jump_target = v[i].jt; branch_taken = v[i].bt; branch_target = v[i].btgt;
      #1;
      chk($sformatf("v%0d_pc", i), pc, prev_pc);
      chk($sformatf("v%0d_npc", i), npc, prev_pc + 16'd1);
      chk($sformatf("v%0d_fetch_en", i), {15'd0, fetch_en}, {15'd0, v[i].fe});
      chk($sformatf("v%0d_flush", i), {15'd0, flush}, {15'd0, v[i].fl});
      chk($sformatf("v%0d_pending", i), {15'd0, pending}, {15'd0, v[i].pd});
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc_after", i), pc, v[i].pc_after);
      chk($sformatf("v%0d_cnt_after", i), fetch_cnt, v[i].cnt_after);
      prev_pc = v[i].pc_after;
    end

    // idle until the fetch counter saturates its 16 bits, then check its wrap
    stall = 0; mem_conflict = 0; jump_en = 0; branch_taken = 0;
    n = 0;
    while (fetch_cnt != 16'hFFFF && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cnt_reach_ffff", fetch_cnt, 16'hFFFF);
    chk("pc_at_cnt_ffff", pc, 16'hFFF8);
    @(posedge clk); #1;
    chk("cnt_wrap", fetch_cnt, 16'h0000);
    chk("pc_after_cnt_wrap", pc, 16'hFFF9);

    // park a redirect, then reset asynchronously mid-cycle
    jump_en = 1; jump_target = 16'h0500; mem_conflict = 1;
    @(posedge clk); #1;
    chk("pend_entered", {15'd0, pending}, 16'd1);
    chk("pend_pc_held", pc, 16'hFFF9);
    jump_en = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_pc", pc, 16'h0000);
    chk("async_rst_pending", {15'd0, pending}, 16'd0);
    chk("async_rst_fetch_en", {15'd0, fetch_en}, 16'd0);
    chk("async_rst_flush", {15'd0, flush}, 16'd1);
    chk("async_rst_cnt", fetch_cnt, 16'h0000);
    @(negedge clk);
    rst = 0; mem_conflict = 0;
    #1;
    chk("post_rst_pc", pc, 16'h0000);
    chk("post_rst_fetch_en", {15'd0, fetch_en}, 16'd1);
    chk("post_rst_flush", {15'd0, flush}, 16'd0);
    @(posedge clk); #1;
    chk("post_rst_advance", pc, 16'h0001);
    chk("post_rst_pending", {15'd0, pending}, 16'd0);
    chk("post_rst_cnt", fetch_cnt, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
